// File: rtl/pool_window_gen.sv
// Stride-2 2x2 window generator feeding the max-pool comparator.
// Buffers one even row and emits a window when the odd-row, odd-column pixel arrives.
module pool_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] win_tl,
  output logic [DATA_WIDTH-1:0] win_tr,
  output logic [DATA_WIDTH-1:0] win_bl,
  output logic [DATA_WIDTH-1:0] win_br,
  output logic                  out_last
);

  localparam int PW = 2 * (IMG_WIDTH / 2);
  localparam int PH = 2 * (IMG_HEIGHT / 2);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] left_reg;

  logic in_pool;
  logic completing;
  logic accept;
  logic last_pos;

  // Handshake: a transfer occurs on a rising edge where valid && ready. Once
  // out_valid is high, the window and out_last hold until out_ready is seen.
  // in_ready only drops when a completing pixel would overwrite a stalled window.
  assign in_pool    = (int'(col) < PW) && (int'(row) < PH);
  assign completing = in_pool && row[0] && col[0];
  assign in_ready   = !(completing && out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign last_pos   = (int'(row) == PH - 1) && (int'(col) == PW - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer holds the top row of each window pair; no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && (int'(row) < PH)) begin
      linebuf[col] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_reg <= '0;
    end else if (accept && in_pool && row[0] && !col[0]) begin
      left_reg <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win_tl    <= '0;
      win_tr    <= '0;
      win_bl    <= '0;
      win_br    <= '0;
    end else if (accept && completing) begin
      out_valid <= 1'b1;
      out_last  <= last_pos;
      win_tl    <= linebuf[col - CW'(1)];
      win_tr    <= linebuf[col];
      win_bl    <= left_reg;
      win_br    <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: 4x4 instance (tables, backpressure, reset, random)
// and a 5x3 instance for the floor-pooling discard case.
module tb_pool_window_gen;

  localparam int DW = 8;
  typedef logic [4*DW:0] win_t;  // {last, tl, tr, bl, br}

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          ov;
    logic [4*DW-1:0] win;
    logic          last;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic [DW-1:0] in_data_a, tl_a, tr_a, bl_a, br_a;
  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [DW-1:0] in_data_b, tl_b, tr_b, bl_b, br_b;

  pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .win_tl(tl_a), .win_tr(tr_a), .win_bl(bl_a), .win_br(br_a),
    .out_last(out_last_a)
  );

  pool_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .win_tl(tl_b), .win_tr(tr_b), .win_bl(bl_b), .win_br(br_b),
    .out_last(out_last_b)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   checks = 0;
  int   failures = 0;
  win_t exp_q[$];
  logic stall_prev;
  win_t prev_win;
  logic [DW-1:0] frame [16];
  vec_t tbl [17];

  function automatic win_t cur_a();
    return {out_last_a, tl_a, tr_a, bl_a, br_a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    in_valid_a  = v;
    in_data_a   = d;
    out_ready_a = r;
    #1;
  endtask

  // One cycle with scoreboard: stall stability and in-order window matching.
  task automatic cyc_a(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
    win_t w;
    drive_a(v, d, r);
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid_a), 64'(1));
      check("stall_hold", 64'(cur_a()), 64'(prev_win));
    end
    if (out_valid_a && out_ready_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window actual=%0h expected=none", cur_a());
      end else begin
        w = exp_q.pop_front();
        check("window", 64'(cur_a()), 64'(w));
      end
    end
    stall_prev = out_valid_a && !out_ready_a;
    prev_win   = cur_a();
    acc        = v && in_ready_a;
  endtask

  // Reference model: windows of a 4x4 frame in raster order of window position.
  task automatic push_model();
    for (int wr = 0; wr < 2; wr++) begin
      for (int wc = 0; wc < 2; wc++) begin
        exp_q.push_back({(wr == 1 && wc == 1),
                         frame[(2*wr)*4 + 2*wc], frame[(2*wr)*4 + 2*wc + 1],
                         frame[(2*wr+1)*4 + 2*wc], frame[(2*wr+1)*4 + 2*wc + 1]});
      end
    end
  endtask

  task automatic send_frame(input bit rnd);
    int   i;
    int   budget;
    logic v, r, acc;
    push_model();
    i = 0;
    budget = 0;
    while (i < 16 && budget < 1000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      cyc_a(v, frame[i], r, acc);
      if (acc) i++;
      budget++;
    end
    if (i < 16) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d expected=16", i);
    end
  endtask

  task automatic drain();
    int   n;
    logic acc;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cyc_a(1'b0, '0, 1'b1, acc);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int   nb, first_seen, c, i, low_cnt, low_other;
    logic r, acc;
    win_t exp_b [2];

    // Table for a plain 4x4 frame 0..15 with out_ready held high
    for (int k = 0; k < 17; k++) tbl[k] = '{(k < 16), DW'(k), 1'b0, '0, 1'b0};
    tbl[6]  = '{1'b1, 8'd6,  1'b1, 32'h00010405, 1'b0};
    tbl[8]  = '{1'b1, 8'd8,  1'b1, 32'h02030607, 1'b0};
    tbl[14] = '{1'b1, 8'd14, 1'b1, 32'h08090c0d, 1'b0};
    tbl[16] = '{1'b0, 8'd0,  1'b1, 32'h0a0b0e0f, 1'b1};
    exp_b[0] = {1'b0, 8'd0, 8'd1, 8'd5, 8'd6};
    exp_b[1] = {1'b1, 8'd2, 8'd3, 8'd7, 8'd8};

    // Reset
    reset = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    stall_prev = 1'b0;
    prev_win = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_a", 64'(out_valid_a), 64'(0));
    check("rst_win_a", 64'(cur_a()), 64'(0));
    check("rst_valid_b", 64'(out_valid_b), 64'(0));
    check("rst_win_b", 64'({out_last_b, tl_b, tr_b, bl_b, br_b}), 64'(0));
    reset = 1'b0;

    // Table-driven 4x4 frame
    for (int k = 0; k < 17; k++) begin
      drive_a(tbl[k].vin, tbl[k].din, 1'b1);
      check("tbl_valid", 64'(out_valid_a), 64'(tbl[k].ov));
      check("tbl_ready", 64'(in_ready_a), 64'(1));
      if (tbl[k].ov) check("tbl_win", 64'(cur_a()), 64'({tbl[k].last, tbl[k].win}));
    end

    // Backpressure: out_ready low until 3 cycles after first out_valid
    for (int k = 0; k < 16; k++) frame[k] = DW'(k);
    push_model();
    i = 0; c = 0; first_seen = -1; low_cnt = 0; low_other = 0;
    while (i < 16 && c < 200) begin
      r = (first_seen >= 0) && (c >= first_seen + 3);
      cyc_a(1'b1, frame[i], r, acc);
      if (out_valid_a && first_seen < 0) first_seen = c;
      if (!in_ready_a) begin
        low_cnt++;
        if (i != 7) low_other++;
      end
      if (acc) i++;
      c++;
    end
    drain();
    check("bp_ready_low_cycles", 64'(low_cnt), 64'(2));
    check("bp_ready_low_other", 64'(low_other), 64'(0));

    // 5x3 frame: only two windows, trailing column and last row discarded
    nb = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_valid_b  = (k < 15);
      in_data_b   = DW'(k);
      out_ready_b = 1'b1;
      #1;
      check("b_ready", 64'(in_ready_b), 64'(1));
      if (out_valid_b) begin
        if (nb < 2) check("b_win", 64'({out_last_b, tl_b, tr_b, bl_b, br_b}), 64'(exp_b[nb]));
        nb++;
      end
    end
    in_valid_b = 1'b0;
    check("b_count", 64'(nb), 64'(2));

    // Back-to-back frames 240..255 then 0..15
    for (int k = 0; k < 16; k++) frame[k] = DW'(240 + k);
    send_frame(1'b0);
    for (int k = 0; k < 16; k++) frame[k] = DW'(k);
    send_frame(1'b0);
    drain();

    // Reset mid-row 1 with a pending window
    for (int k = 0; k < 6; k++) drive_a(1'b1, DW'(k), 1'b0);
    drive_a(1'b0, '0, 1'b0);
    check("rst_pre_valid", 64'(out_valid_a), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid_a), 64'(0));
    check("rst_async_win", 64'(cur_a()), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    stall_prev = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) frame[k] = DW'(k);
    send_frame(1'b0);
    drain();

    // Random in_valid / out_ready over 50 frames
    repeat (50) begin
      for (int k = 0; k < 16; k++) frame[k] = DW'($urandom_range(0, 255));
      send_frame(1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
